// File: rtl/param_ram.sv
// Parametrised 1R/1W word-addressed RAM with byte-lane writes, range exceptions
// and a reset-triggered clear sweep; reads return after RD_LAT cycles, writes ack after one.
module param_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   output logic                busy,
   input  logic                r_req,
   input  logic [ADDR_W-1:0]   r_addr,
   output logic [DATA_W-1:0]   r_data,
   output logic                r_valid,
   output logic                r_exc,
   input  logic                w_req,
   input  logic [ADDR_W-1:0]   w_addr,
   input  logic [DATA_W-1:0]   w_data,
   input  logic [DATA_W/8-1:0] w_be,
   output logic                w_ack,
   output logic                w_exc
);

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {CLEAR, READY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               rd_acc, wr_acc, r_in_rng, w_in_rng;
   logic [CNT_W-1:0]   r_idx, w_idx;
   logic [DATA_W-1:0]  rd_word;

   logic               s1_vld_q, s1_vld_d;
   logic               s1_exc_q, s1_exc_d;
   logic [DATA_W-1:0]  s1_dat_q, s1_dat_d;
   logic               w_ack_q, w_ack_d;
   logic               w_exc_q, w_exc_d;

   // Unsigned compare on the full address so out-of-range never aliases.
   assign r_in_rng = {1'b0, r_addr} < DEPTH_X;
   assign w_in_rng = {1'b0, w_addr} < DEPTH_X;
   assign r_idx    = r_addr[CNT_W-1:0];
   assign w_idx    = w_addr[CNT_W-1:0];
   assign rd_acc   = (state_q == READY) && r_req;
   assign wr_acc   = (state_q == READY) && w_req;
   assign busy     = (state_q == CLEAR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
         end else if (wr_acc && w_in_rng) begin
            for (int i = 0; i < NB; i++) begin
               if (w_be[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
         end
      end
   end

   // Write-first: a same-address write on this edge overlays its enabled lanes.
   always_comb begin
      rd_word = mem[r_idx];
      if (wr_acc && w_in_rng && (w_addr == r_addr)) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) rd_word[8*i +: 8] = w_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      s1_vld_d = rd_acc && r_in_rng;
      s1_exc_d = rd_acc && !r_in_rng;
      s1_dat_d = s1_dat_q;
      if (rd_acc) s1_dat_d = r_in_rng ? rd_word : '0;
      w_ack_d  = wr_acc && w_in_rng;
      w_exc_d  = wr_acc && !w_in_rng;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_exc_q <= 1'b0;
         s1_dat_q <= '0;
         w_ack_q  <= 1'b0;
         w_exc_q  <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_exc_q <= s1_exc_d;
         s1_dat_q <= s1_dat_d;
         w_ack_q  <= w_ack_d;
         w_exc_q  <= w_exc_d;
      end
   end

   assign w_ack = w_ack_q;
   assign w_exc = w_exc_q;

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_vld_q, s2_exc_q;
         logic [DATA_W-1:0] s2_dat_q, s2_dat_d;

         always_comb begin
            s2_dat_d = s2_dat_q;
            if (s1_vld_q || s1_exc_q) s2_dat_d = s1_dat_q;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s2_vld_q <= 1'b0;
               s2_exc_q <= 1'b0;
               s2_dat_q <= '0;
            end else begin
               s2_vld_q <= s1_vld_q;
               s2_exc_q <= s1_exc_q;
               s2_dat_q <= s2_dat_d;
            end
         end

         assign r_valid = s2_vld_q;
         assign r_exc   = s2_exc_q;
         assign r_data  = s2_dat_q;
      end else begin : g_lat1
         assign r_valid = s1_vld_q;
         assign r_exc   = s1_exc_q;
         assign r_data  = s1_dat_q;
      end
   endgenerate

endmodule
